pipe_reg_em_elastic: RTL and testbench
======================================

Name: pipe_reg_em_elastic

Overview:
- Parametrised, elastic Execute→Memory pipeline register. Successor to the fixed E/M latch.
- Carries the instruction payload: IR, store data V2, ALU/MDU result AMO, destination A3 and PC4.
- Adds valid/ready handshaking, a one-entry skid buffer so In_Ready is purely registered, a synchronous flush, and a saturating back-pressure counter.
- Sits between the ALU/MDU stage and the data-memory stage.

Parameters:
- DATA_W, 32, width of IR, V2, AMO and PC4 fields
- REG_W, 5, width of the A3 destination-register field
- PC_RESET, 32'h0000_3000, PC4 value of a bubble or reset entry
- CNT_W, 16, width of the Stall_Count performance counter

Ports:
- Clock  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- Flush  in  1  synchronous kill of all held entries
- In_Valid  in  1  E stage presents a valid instruction
- In_Ready  out  1  register can accept an instruction this cycle
- IR_E  in  DATA_W  instruction word
- V2_E  in  DATA_W  forwarded rt value (store data)
- AMO_E  in  DATA_W  ALU/MDU result
- A3_E  in  REG_W  destination register
- PC4_E  in  DATA_W  PC+4
- Out_Valid  out  1  M outputs hold a valid instruction
- Out_Ready  in  1  M stage consumes the output this cycle
- IR_M, V2_M, AMO_M  out  DATA_W  registered payload
- A3_M  out  REG_W  registered destination
- PC4_M  out  DATA_W  registered PC+4
- Occupancy  out  2  number of held entries (0..2)
- Stall_Count  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Clock is Clock. Reset is synchronous and active-high (Reset=1 sampled on a posedge).
- Transfer definitions: in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
- Two storage entries. MAIN drives the *_M outputs directly. SKID is internal.
- States:
  - EMPTY (Occupancy=0)
  - ONE (Occupancy=1)
  - FULL (Occupancy=2)
- Combinational outputs: Out_Valid = (state != EMPTY); In_Ready = (state != FULL). Both are functions of state only, with no combinational path from In_Valid or Out_Ready.
- EMPTY:
  - in_fire → MAIN ← input, go to ONE.
- ONE:
  - in_fire & out_fire → MAIN ← input, stay in ONE.
  - in_fire only → SKID ← input, go to FULL.
  - out_fire only → MAIN ← bubble, go to EMPTY.
  - neither → hold.
- FULL:
  - out_fire → MAIN ← SKID, SKID ← bubble, go to ONE. In_Ready=0, so no input is accepted.
  - otherwise → hold everything.
- Bubble value: IR=0 (nop), V2=0, AMO=0, A3=0, PC4=PC_RESET.
- Latency: 1 cycle from in_fire to Out_Valid when the register is EMPTY or draining. Full throughput is 1 instruction per cycle while Out_Ready=1.
- Flush (when Reset=0):
  - MAIN and SKID ← bubble, state ← EMPTY.
  - A same-cycle in_fire is dropped; a same-cycle out_fire is still considered consumed by M.
  - Stall_Count is unaffected.
- Reset:
  - Highest priority, including mid-transfer and while FULL.
  - MAIN, SKID ← bubble; state ← EMPTY; Stall_Count ← 0.
  - All outputs after reset: IR_M=V2_M=AMO_M=0, A3_M=0, PC4_M=PC_RESET, Out_Valid=0, In_Ready=1, Occupancy=0.
- Stall_Count:
  - Increments by 1 on each cycle with Out_Valid=1 and Out_Ready=0.
  - Saturates at 2^CNT_W−1 with no wrap.
- Ordering: output order equals acceptance order. No entry is ever dropped except by Flush or Reset.
- Initial-block values equal the reset values, so simulation starts sane without a Reset pulse.

Decomposition:
- Shared package pipe_pkg:
  - state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2
  - PC_RESET_DEFAULT = 32'h0000_3000
  - bubble constants: NOP_IR = 0, ZERO_REG = 0
- Natural sub-module: pipe_payload_entry. It is instantiated twice (MAIN, SKID) and holds one {IR,V2,AMO,A3,PC4} tuple with load, clear-to-bubble and hold controls.
- FSM, handshake and counter logic stay in the top module.

Test Plan:
1. Reset then stream IR_E=0x00221820,0x8C430004,0xAC430008 with In_Valid=1, Out_Ready=1 → the words appear on IR_M one cycle later, in order; Out_Valid=1 each cycle; Occupancy=1.
2. Load IR=0x11111111, then Out_Ready=0 and present IR=0x22222222 → Occupancy=2, In_Ready=0, IR_M holds 0x11111111. Raise Out_Ready → IR_M=0x11111111 consumed, next IR_M=0x22222222, then Out_Valid=0 with IR_M=0, PC4_M=0x00003000.
3. FULL state, assert Flush with In_Valid=1 → next cycle Occupancy=0, Out_Valid=0, In_Ready=1, A3_M=0, PC4_M=0x00003000; the flushed and incoming words never appear.
4. Hold Out_Valid=1 and Out_Ready=0 for 5 cycles → Stall_Count=5. With CNT_W=2, hold for 6 cycles → Stall_Count saturates at 3.
5. Assert Reset while FULL and in_fire is attempted → next cycle all outputs at reset values, Stall_Count=0, In_Ready=1.
6. Alternate Out_Ready 1/0 while In_Valid=1 with an incrementing PC4_E from 0x3004 → PC4_M sequence is gap-free and monotonic, with no duplicates or losses.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and bubble constants for the E/M pipeline register
package pipe_pkg;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_IR = 32'd0;
  localparam logic [31:0] ZERO_REG = 32'd0;
endpackage

// File: rtl/pipe_payload_entry.sv
// pipe_payload_entry: one {IR,V2,AMO,A3,PC4} slot with clear-to-bubble, load and hold
module pipe_payload_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEFAULT),
  parameter int W = 4 * DATA_W + REG_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] BUBBLE = {DATA_W'(NOP_IR), {(2 * DATA_W){1'b0}}, REG_W'(ZERO_REG), PC_RESET};
  logic [W-1:0] r = BUBBLE;
  assign q = r;
  always_ff @(posedge clk)
    if (clear) r <= BUBBLE;
    else if (load) r <= d;
endmodule

// File: rtl/pipe_reg_em_elastic.sv
// pipe_reg_em_elastic: elastic E->M pipeline register with skid buffer, flush and stall counter
module pipe_reg_em_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEFAULT),
  parameter int CNT_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] IR_E,
  input  logic [DATA_W-1:0] V2_E,
  input  logic [DATA_W-1:0] AMO_E,
  input  logic [REG_W-1:0]  A3_E,
  input  logic [DATA_W-1:0] PC4_E,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] IR_M,
  output logic [DATA_W-1:0] V2_M,
  output logic [DATA_W-1:0] AMO_M,
  output logic [REG_W-1:0]  A3_M,
  output logic [DATA_W-1:0] PC4_M,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Stall_Count
);
  localparam int W = 4 * DATA_W + REG_W;
  logic [1:0] state = EMPTY;
  logic [1:0] nxt;
  logic [CNT_W-1:0] stall_cnt = '0;
  logic [W-1:0] main_q, skid_q;
  logic in_fire, out_fire, kill;
  assign Out_Valid = state != EMPTY;
  assign In_Ready = state != FULL;
  assign Occupancy = state;
  assign Stall_Count = stall_cnt;
  assign in_fire = In_Valid & In_Ready;
  assign out_fire = Out_Valid & Out_Ready;
  assign kill = Reset | Flush;
  assign {IR_M, V2_M, AMO_M, A3_M, PC4_M} = main_q;
  always_comb
    nxt = Flush ? EMPTY :
          state == EMPTY ? (in_fire ? ONE : EMPTY) :
          state == ONE ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
          (out_fire ? ONE : FULL);
  always_ff @(posedge Clock)
    if (Reset) state <= EMPTY;
    else state <= nxt;
  always_ff @(posedge Clock)
    if (Reset) stall_cnt <= '0;
    else if (Out_Valid && !Out_Ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  // MAIN refills from SKID when draining a FULL register, otherwise straight from E
  pipe_payload_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .PC_RESET(PC_RESET)) u_main (
    .clk  (Clock),
    .clear(kill | (state == ONE && out_fire && !in_fire)),
    .load ((in_fire && (state == EMPTY || out_fire)) || (state == FULL && out_fire)),
    .d    (state == FULL ? skid_q : {IR_E, V2_E, AMO_E, A3_E, PC4_E}),
    .q    (main_q)
  );
  pipe_payload_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .PC_RESET(PC_RESET)) u_skid (
    .clk  (Clock),
    .clear(kill | (state == FULL && out_fire)),
    .load (state == ONE && in_fire && !out_fire),
    .d    ({IR_E, V2_E, AMO_E, A3_E, PC4_E}),
    .q    (skid_q)
  );
endmodule

// File: tb/tb_pipe_reg_em_elastic.sv
// tb_pipe_reg_em_elastic: randomized scoreboard bench against a queue-based reference model
module tb_pipe_reg_em_elastic;
  typedef struct packed {
    logic [31:0] ir, v2, amo;
    logic [4:0]  a3;
    logic [31:0] pc4;
  } pl_t;
  localparam pl_t BUBBLE = '{32'd0, 32'd0, 32'd0, 5'd0, 32'h0000_3000};
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  pl_t din = '0, dout, dout2;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [1:0] occ, occ2;
  logic [15:0] stall;
  logic [1:0] stall2;
  pl_t exp_q[$];
  int exp_stall = 0, exp_stall2 = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_reg_em_elastic dut (
    .Clock(clk), .Reset(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_ready),
    .IR_E(din.ir), .V2_E(din.v2), .AMO_E(din.amo), .A3_E(din.a3), .PC4_E(din.pc4),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .IR_M(dout.ir), .V2_M(dout.v2), .AMO_M(dout.amo), .A3_M(dout.a3), .PC4_M(dout.pc4),
    .Occupancy(occ), .Stall_Count(stall)
  );
  pipe_reg_em_elastic #(.CNT_W(2)) dut_sat (
    .Clock(clk), .Reset(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_ready2),
    .IR_E(din.ir), .V2_E(din.v2), .AMO_E(din.amo), .A3_E(din.a3), .PC4_E(din.pc4),
    .Out_Valid(out_valid2), .Out_Ready(out_ready),
    .IR_M(dout2.ir), .V2_M(dout2.v2), .AMO_M(dout2.amo), .A3_M(dout2.a3), .PC4_M(dout2.pc4),
    .Occupancy(occ2), .Stall_Count(stall2)
  );
  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask
  // Reference model: an ordered queue of accepted payloads holding at most two entries
  always @(posedge clk) begin
    automatic bit ov = exp_q.size() > 0;
    automatic bit ir = exp_q.size() < 2;
    if (rst) begin
      exp_q.delete();
      exp_stall = 0;
      exp_stall2 = 0;
    end else begin
      if (ov && !out_ready) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall2 < 3) exp_stall2++;
      end
      if (flush) exp_q.delete();
      else begin
        if (ov && out_ready) void'(exp_q.pop_front());
        if (in_valid && ir) exp_q.push_back(din);
      end
    end
  end
  always @(negedge clk) begin
    chk("out_valid", 136'(out_valid), 136'(exp_q.size() > 0));
    chk("in_ready", 136'(in_ready), 136'(exp_q.size() < 2));
    chk("occupancy", 136'(occ), 136'(exp_q.size()));
    chk("stall_count", 136'(stall), 136'(exp_stall));
    chk("stall_count_sat", 136'(stall2), 136'(exp_stall2));
    chk("payload", 136'(dout), 136'(exp_q.size() > 0 ? exp_q[0] : BUBBLE));
    chk("payload_sat_dut", 136'(dout2), 136'(exp_q.size() > 0 ? exp_q[0] : BUBBLE));
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      automatic int phase = c / 500;
      @(negedge clk);
      in_valid = phase == 2 ? 1'b1 : $urandom_range(0, 3) != 0;
      out_ready = phase == 1 ? $urandom_range(0, 3) == 0 :
                  phase == 2 ? c[0] :
                  phase == 3 ? ((c / 12) % 2 == 0) : $urandom_range(0, 1) == 1;
      flush = phase != 2 && $urandom_range(0, 50) == 0;
      rst = phase != 2 && $urandom_range(0, 150) == 0;
      din = '{$urandom, $urandom, $urandom, 5'($urandom), 32'h3004 + 32'(4 * c)};
    end
    @(negedge clk);
    #1 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
